// File: rtl/act_s2_pipe_pkg.sv
// ACT-C2 select encoding shared by the lane cell and the pipeline.
package act_pkg;

   localparam logic [1:0] SEL_D00 = 2'b00;
   localparam logic [1:0] SEL_D01 = 2'b10;
   localparam logic [1:0] SEL_D10 = 2'b01;
   localparam logic [1:0] SEL_D11 = 2'b11;

   // Returns {S1,S0} for one ACT-C2 cell.
   function automatic logic [1:0] act_sel(input logic a1, input logic b1,
                                          input logic a0, input logic b0);
      return {a1 | b1, a0 & b0};
   endfunction

endpackage

// File: rtl/act_s2_pipe_if.sv
// Input and output handshake bundle of the ACT-C2 pipeline.
interface act_s2_pipe_if #(
   parameter int unsigned BITS  = 2,
   parameter int unsigned LANES = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*BITS-1:0]   D00;
   logic [LANES*BITS-1:0]   D01;
   logic [LANES*BITS-1:0]   D10;
   logic [LANES*BITS-1:0]   D11;
   logic [LANES-1:0]        A1;
   logic [LANES-1:0]        B1;
   logic [LANES-1:0]        A0;
   logic [LANES-1:0]        B0;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*BITS-1:0]   out;
   logic [2*LANES-1:0]      sel;

   modport master (
      output in_valid, D00, D01, D10, D11, A1, B1, A0, B0, out_ready,
      input  in_ready, out_valid, out, sel
   );

   modport slave (
      input  in_valid, D00, D01, D10, D11, A1, B1, A0, B0, out_ready,
      output in_ready, out_valid, out, sel
   );
endinterface

// File: rtl/act_s2_pipe_lane.sv
// One combinational ACT-C2 cell: picks one of four BITS-wide words.
module act_c2_lane
   import act_pkg::*;
#(
   parameter int unsigned BITS = 2
) (
   input  logic [BITS-1:0] d00,
   input  logic [BITS-1:0] d01,
   input  logic [BITS-1:0] d10,
   input  logic [BITS-1:0] d11,
   input  logic            a1,
   input  logic            b1,
   input  logic            a0,
   input  logic            b0,
   output logic [BITS-1:0] y,
   output logic [1:0]      s
);

   always_comb begin
      s = act_sel(a1, b1, a0, b0);
      case (s)
         SEL_D00: y = d00;
         SEL_D01: y = d01;
         SEL_D10: y = d10;
         default: y = d11;
      endcase
   end

endmodule

// File: rtl/act_s2_pipe.sv
// LANES ACT-C2 cells feeding a stage-1 register and a 2-entry output skid FIFO.
module act_s2_pipe #(
   parameter int unsigned BITS  = 2,
   parameter int unsigned LANES = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   act_s2_pipe_if.slave     bus,
   output logic [CNT_W-1:0] tx_count
);

   localparam int unsigned W  = LANES * BITS;
   localparam int unsigned SW = 2 * LANES;

   logic [W-1:0]  sel_data;
   logic [SW-1:0] sel_bits;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_c2_lane #(.BITS(BITS)) u_lane (
         .d00 (bus.D00[i*BITS +: BITS]),
         .d01 (bus.D01[i*BITS +: BITS]),
         .d10 (bus.D10[i*BITS +: BITS]),
         .d11 (bus.D11[i*BITS +: BITS]),
         .a1  (bus.A1[i]),
         .b1  (bus.B1[i]),
         .a0  (bus.A0[i]),
         .b0  (bus.B0[i]),
         .y   (sel_data[i*BITS +: BITS]),
         .s   (sel_bits[2*i +: 2])
      );
   end

   logic          s1_v;
   logic [W-1:0]  s1_data;
   logic [SW-1:0] s1_sel;
   logic [W-1:0]  fifo_data [2];
   logic [SW-1:0] fifo_sel  [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    fifo_cnt;
   logic          pop;
   logic          adv;
   logic          acc;

   // A pop frees a slot in the same cycle, so a full FIFO still lets stage 1 advance.
   always_comb begin
      bus.out_valid = (fifo_cnt != 2'd0);
      pop           = bus.out_valid && bus.out_ready;
      adv           = s1_v && ((fifo_cnt != 2'd2) || pop);
      bus.in_ready  = !s1_v || adv;
      acc           = bus.in_valid && bus.in_ready;
      bus.out       = bus.out_valid ? fifo_data[rd_ptr] : '0;
      bus.sel       = bus.out_valid ? fifo_sel[rd_ptr]  : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= '0;
         tx_count <= '0;
      end else begin
         if (acc) begin
            s1_v <= 1'b1;
         end else if (adv) begin
            s1_v <= 1'b0;
         end
         if (adv) begin
            wr_ptr <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({adv, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (acc) begin
            tx_count <= tx_count + CNT_W'(1);
         end
      end
   end

   // Payload storage is qualified by the control state above and needs no reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         s1_data <= sel_data;
         s1_sel  <= sel_bits;
      end
      if (adv) begin
         fifo_data[wr_ptr] <= s1_data;
         fifo_sel[wr_ptr]  <= s1_sel;
      end
   end

endmodule

// File: tb/tb_act_s2_pipe.sv
// Scoreboard bench for act_s2_pipe: randomized and directed traffic against a lane-level model.
module tb_act_s2_pipe;

   localparam int unsigned BITS  = 2;
   localparam int unsigned LANES = 4;
   localparam int unsigned W     = LANES * BITS;
   localparam int unsigned SW    = 2 * LANES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   act_s2_pipe_if #(.BITS(BITS), .LANES(LANES)) bus ();
   act_s2_pipe_if #(.BITS(BITS), .LANES(LANES)) bus2 ();
   logic [15:0] tx_count;
   logic [2:0]  tx_count2;

   act_s2_pipe #(.BITS(BITS), .LANES(LANES), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .tx_count(tx_count)
   );

   act_s2_pipe #(.BITS(BITS), .LANES(LANES), .CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .tx_count(tx_count2)
   );

   typedef struct {
      logic [W-1:0]  out;
      logic [SW-1:0] sel;
      int            acc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   n_acc    = 0;
   int   last_acc = -10;
   bit   mon_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Each lane picks by the ACT-C2 truth table: idx = 2*S1 + S0 -> D00, D10, D01, D11.
   function automatic exp_t model(input logic [W-1:0] d00, input logic [W-1:0] d01,
                                  input logic [W-1:0] d10, input logic [W-1:0] d11,
                                  input logic [LANES-1:0] a1, input logic [LANES-1:0] b1,
                                  input logic [LANES-1:0] a0, input logic [LANES-1:0] b0);
      exp_t e;
      e.out = '0;
      e.sel = '0;
      e.acc = 0;
      for (int l = 0; l < LANES; l++) begin
         int s0;
         int s1;
         int idx;
         logic [BITS-1:0] w;
         s0  = (a0[l] && b0[l]) ? 1 : 0;
         s1  = (a1[l] || b1[l]) ? 1 : 0;
         idx = 2 * s1 + s0;
         case (idx)
            0:       w = d00[l*BITS +: BITS];
            1:       w = d10[l*BITS +: BITS];
            2:       w = d01[l*BITS +: BITS];
            default: w = d11[l*BITS +: BITS];
         endcase
         e.out[l*BITS +: BITS] = w;
         e.sel[2*l]            = (s0 != 0);
         e.sel[2*l+1]          = (s1 != 0);
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
      end
   endtask

   task automatic drive(input bit v,
                        input logic [W-1:0] d00, input logic [W-1:0] d01,
                        input logic [W-1:0] d10, input logic [W-1:0] d11,
                        input logic [LANES-1:0] a1, input logic [LANES-1:0] b1,
                        input logic [LANES-1:0] a0, input logic [LANES-1:0] b0,
                        input bit ordy, input bit r);
      exp_t e;
      @(posedge clk);
      #1;
      rst           = r;
      bus.in_valid  = v;
      bus.D00       = d00;
      bus.D01       = d01;
      bus.D10       = d10;
      bus.D11       = d11;
      bus.A1        = a1;
      bus.B1        = b1;
      bus.A0        = a0;
      bus.B0        = b0;
      bus.out_ready = ordy;
      @(negedge clk);
      if (r) begin
         q.delete();
         n_acc    = 0;
         last_acc = -10;
      end else if (v && bus.in_ready === 1'b1) begin
         e     = model(d00, d01, d10, d11, a1, b1, a0, b0);
         e.acc = cyc + 1;
         q.push_back(e);
         n_acc++;
         last_acc = cyc + 1;
      end
   endtask

   task automatic rnd(input bit v, input bit ordy, input bit r);
      drive(v, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            LANES'($urandom), LANES'($urandom), LANES'($urandom), LANES'($urandom), ordy, r);
   endtask

   // Monitor: occupancy counts items accepted by now; the head is visible one edge after its accept edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && !rst) begin
            int   n;
            int   t;
            bit   hv;
            n = 0;
            foreach (q[i]) if (q[i].acc <= cyc) n++;
            hv = (q.size() > 0) && (q[0].acc <= cyc - 1);
            t  = n_acc - ((last_acc == cyc + 1) ? 1 : 0);
            chk("in_ready", 32'(bus.in_ready), 32'((n < 3) || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(hv));
            chk("tx_count", 32'(tx_count), t & 32'hFFFF);
            if (hv) begin
               chk("out", 32'(bus.out), 32'(q[0].out));
               chk("sel", 32'(bus.sel), 32'(q[0].sel));
               if (bus.out_ready) void'(q.pop_front());
            end else begin
               chk("out_idle", 32'(bus.out), 32'd0);
               chk("sel_idle", 32'(bus.sel), 32'd0);
            end
         end
      end
   end

   initial begin
      int got;
      bus.in_valid   = 1'b0;
      bus.D00 = '0; bus.D01 = '0; bus.D10 = '0; bus.D11 = '0;
      bus.A1  = '0; bus.B1  = '0; bus.A0  = '0; bus.B0  = '0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.D00 = '0; bus2.D01 = '0; bus2.D10 = '0; bus2.D11 = '0;
      bus2.A1  = '0; bus2.B1  = '0; bus2.A0  = '0; bus2.B0  = '0;
      bus2.out_ready = 1'b1;

      rnd(0, 1, 1);
      rnd(0, 1, 1);
      mon_en = 1'b1;

      // Select table: D00=0, D01=1, D10=2, D11=3 in every lane.
      drive(1, {4{2'd0}}, {4{2'd1}}, {4{2'd2}}, {4{2'd3}}, 4'h0, 4'h0, 4'hF, 4'hF, 1, 0);
      drive(1, {4{2'd0}}, {4{2'd1}}, {4{2'd2}}, {4{2'd3}}, 4'hF, 4'h0, 4'hF, 4'h0, 1, 0);
      drive(1, {4{2'd0}}, {4{2'd1}}, {4{2'd2}}, {4{2'd3}}, 4'hF, 4'hF, 4'hF, 4'hF, 1, 0);
      drive(1, {4{2'd0}}, {4{2'd1}}, {4{2'd2}}, {4{2'd3}}, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
      repeat (3) rnd(0, 1, 0);

      repeat (10) rnd(1, 1, 0);
      repeat (4) rnd(0, 1, 0);

      repeat (5) rnd(1, 0, 0);
      repeat (5) rnd(1, 1, 0);
      repeat (4) rnd(0, 1, 0);

      repeat (3) rnd(1, 0, 0);
      repeat (6) rnd(1, 1, 0);
      repeat (4) rnd(0, 1, 0);

      repeat (3) rnd(1, 0, 0);
      rnd(1, 0, 1);
      rnd(1, 1, 0);
      repeat (3) rnd(0, 1, 0);

      repeat (400) rnd($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 99) == 0);

      for (int k = 0; k < 20; k++) begin
         if (q.size() == 0) break;
         rnd(0, 1, 0);
      end
      chk("drain_left", 32'(q.size()), 32'd0);

      // Narrow counter: nine accepts on a 3-bit counter leave 1.
      got = 0;
      for (int k = 0; k < 30 && got < 9; k++) begin
         @(posedge clk);
         #1;
         bus2.in_valid = 1'b1;
         @(negedge clk);
         if (bus2.in_ready === 1'b1) got++;
      end
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("tx_wrap", 32'(tx_count2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
